// File: rtl/dbb_slave_mem.sv
// DBB slave responder backed by a flop-array memory of 2^DEPTH_LOG2 full-width beats.
// Independent write (AW/W/B) and read (AR/R) state machines; every burst is treated as INCR.
module dbb_slave_mem #(
    parameter int MEM_DATA_WIDTH  = 512,
    parameter int MEM_WSTRB_WIDTH = MEM_DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 8,
    parameter int LEN_WIDTH       = 4,
    parameter int DEPTH_LOG2      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic [LEN_WIDTH-1:0]       awlen,
    input  logic [2:0]                 awsize,
    input  logic [1:0]                 awburst,
    input  logic [ID_WIDTH-1:0]        awid,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [MEM_DATA_WIDTH-1:0]  wdata,
    input  logic [MEM_WSTRB_WIDTH-1:0] wstrb,
    input  logic                       wlast,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    output logic [ID_WIDTH-1:0]        bid,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [LEN_WIDTH-1:0]       arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    input  logic [ID_WIDTH-1:0]        arid,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [MEM_DATA_WIDTH-1:0]  rdata,
    output logic                       rlast,
    output logic [ID_WIDTH-1:0]        rid,
    output logic                       err_wlast
);

    localparam int B     = $clog2(MEM_WSTRB_WIDTH);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

    logic [ID_WIDTH-1:0]   w_id;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [LEN_WIDTH-1:0]  w_beat;

    logic [DEPTH_LOG2-1:0] r_idx;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat;

    // Size/burst are ignored and address bits outside the beat index alias.
    logic unused_fields;
    assign unused_fields = ^{awaddr, araddr, awsize, awburst, arsize, arburst};

    assign bresp = 2'b00;
    assign rdata = mem[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            err_wlast <= 1'b0;
            w_beat    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_idx   <= awaddr[DEPTH_LOG2+B-1:B];
                        w_len   <= awlen;
                        w_beat  <= '0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        // Beat count ends the burst; wlast is only cross-checked.
                        if (wlast != (w_beat == w_len))
                            err_wlast <= 1'b1;
                        w_idx  <= w_idx + IDX_ONE;
                        w_beat <= w_beat + LEN_ONE;
                        if (w_beat == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory is never reset; writes are blocked while rst is high so contents survive it.
    always_ff @(posedge clk) begin
        if (!rst && wready && wvalid) begin
            for (int i = 0; i < MEM_WSTRB_WIDTH; i++) begin
                if (wstrb[i])
                    mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        r_idx   <= araddr[DEPTH_LOG2+B-1:B];
                        r_len   <= arlen;
                        r_beat  <= '0;
                        rid     <= arid;
                        rlast   <= (arlen == '0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (r_beat == r_len) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_idx  <= r_idx + IDX_ONE;
                            r_beat <= r_beat + LEN_ONE;
                            rlast  <= ((r_beat + LEN_ONE) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbb_slave_mem.sv
// Directed bench for dbb_slave_mem: write/read bursts, strobes, backpressure, wrap,
// wlast error flag, reset mid-burst and same-index read/write collision.
module tb_dbb_slave_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [7:0]   awid;
    logic         wvalid, wready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [7:0]   bid;
    logic         arvalid, arready;
    logic [63:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [7:0]   arid;
    logic         rvalid, rready;
    logic [511:0] rdata;
    logic         rlast;
    logic [7:0]   rid;
    logic         err_wlast;

    int checks = 0;
    int errors = 0;

    logic [511:0] wd    [16];
    logic [63:0]  ws    [16];
    logic [511:0] exp_q [16];

    always #5 clk = ~clk;

    dbb_slave_mem dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid),
        .err_wlast(err_wlast)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [63:0] addr, input int len, input logic [7:0] id,
                               input int bad_beat, input int b_stall);
        checks++;
        if (awready !== 1'b1) begin
            errors++; $display("FAIL aw_ready actual=%0b required=1", awready);
        end
        awvalid = 1'b1; awaddr = addr; awlen = 4'(len); awid = id;
        awsize = 3'd6; awburst = 2'b01;
        step();
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1 || awready !== 1'b0) begin
            errors++; $display("FAIL w_ready_after_aw actual=%0b/%0b required=1/0", wready, awready);
        end
        for (int k = 0; k <= len; k++) begin
            wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
            wlast = (k == len) || (k == bad_beat);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || wready !== 1'b0) begin
            errors++; $display("FAIL b_valid actual=%0b/%0b required=1/0", bvalid, wready);
        end
        checks++;
        if (bid !== id || bresp !== 2'b00) begin
            errors++; $display("FAIL b_fields actual=%0h/%0h required=%0h/0", bid, bresp, id);
        end
        for (int s = 0; s < b_stall; s++) begin
            step();
            checks++;
            if (bvalid !== 1'b1) begin
                errors++; $display("FAIL b_hold cycle=%0d actual=%0b required=1", s, bvalid);
            end
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++; $display("FAIL b_done actual=%0b/%0b required=0/1", bvalid, awready);
        end
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input logic [7:0] id,
                              input int max_stall);
        checks++;
        if (arready !== 1'b1) begin
            errors++; $display("FAIL ar_ready actual=%0b required=1", arready);
        end
        arvalid = 1'b1; araddr = addr; arlen = 4'(len); arid = id;
        arsize = 3'd6; arburst = 2'b01;
        step();
        arvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            int  n;
            bit  go;
            n = 0;
            do begin
                checks++;
                if (rvalid !== 1'b1 || rid !== id || rlast !== (k == len)) begin
                    errors++;
                    $display("FAIL r_ctrl beat=%0d actual=%0b/%0h/%0b required=1/%0h/%0b",
                             k, rvalid, rid, rlast, id, (k == len));
                end
                checks++;
                if (rdata !== exp_q[k]) begin
                    errors++;
                    $display("FAIL r_data beat=%0d actual=%0h required=%0h", k, rdata, exp_q[k]);
                end
                go = (max_stall == 0 || n >= max_stall) ? 1'b1 : 1'($urandom_range(0, 1));
                rready = go;
                step();
                n++;
            end while (!go);
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL r_done actual=%0b/%0b required=0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0; rready = 0;
        repeat (3) step();
        checks++;
        if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rid, err_wlast} !== '0) begin
            errors++;
            $display("FAIL reset_vals actual=%0b%0b%0b %0h %0h %0b%0b%0b %0h %0b required=all zero",
                     awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rid, err_wlast);
        end
        rst = 1'b0;
        step();
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset actual=%0b/%0b required=1/1", awready, arready);
        end
    endtask

    task automatic test_single_beat();
        wd[0] = {64{8'hA5}}; ws[0] = '1;
        write_burst(64'h40, 0, 8'h3C, -1, 0);
        exp_q[0] = {64{8'hA5}};
        read_burst(64'h40, 0, 8'h5A, 0);
    endtask

    task automatic test_strobed_burst();
        for (int k = 0; k < 16; k++) begin
            wd[k] = '1; ws[k] = '1;
        end
        write_burst(64'h0, 15, 8'h11, -1, 0);
        for (int k = 0; k < 16; k++) begin
            wd[k]    = {64{8'(k)}};
            ws[k]    = {32{2'b01}};
            exp_q[k] = {32{8'hFF, 8'(k)}};
        end
        write_burst(64'h0, 15, 8'h22, -1, 0);
        read_burst(64'h0, 15, 8'h33, 0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 8; k++) begin
            wd[k] = {16{32'hC0DE0000 + 32'(k)}}; ws[k] = '1;
            exp_q[k] = wd[k];
        end
        write_burst(64'h400, 7, 8'h44, -1, 5);
        read_burst(64'h400, 7, 8'h55, 3);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            wd[k] = {16{32'h0BAD0000 + 32'(k)}}; ws[k] = '1;
            exp_q[k] = wd[k];
        end
        write_burst(64'hF80, 3, 8'h66, -1, 0);
        read_burst(64'hF80, 3, 8'h67, 0);
        exp_q[0] = {16{32'h0BAD0002}};
        read_burst(64'h0, 0, 8'h68, 0);
    endtask

    task automatic test_wlast();
        checks++;
        if (err_wlast !== 1'b0) begin
            errors++; $display("FAIL err_wlast_clean actual=%0b required=0", err_wlast);
        end
        for (int k = 0; k < 4; k++) begin
            wd[k] = {64{8'h30 + 8'(k)}}; ws[k] = '1;
            exp_q[k] = wd[k];
        end
        write_burst(64'h800, 3, 8'h77, 1, 0);
        checks++;
        if (err_wlast !== 1'b1) begin
            errors++; $display("FAIL err_wlast_set actual=%0b required=1", err_wlast);
        end
        read_burst(64'h800, 3, 8'h78, 0);
        write_burst(64'h800, 3, 8'h79, -1, 0);
        checks++;
        if (err_wlast !== 1'b1) begin
            errors++; $display("FAIL err_wlast_sticky actual=%0b required=1", err_wlast);
        end
    endtask

    task automatic test_reset_mid_burst();
        arvalid = 1'b1; araddr = 64'h400; arlen = 4'd7; arid = 8'h88;
        step();
        arvalid = 1'b0; rready = 1'b1;
        repeat (3) step();
        checks++;
        if (rvalid !== 1'b1 || rdata !== {16{32'hC0DE0003}}) begin
            errors++; $display("FAIL mid_read_beat3 actual=%0b/%0h required=1/%0h",
                               rvalid, rdata, {16{32'hC0DE0003}});
        end
        rst = 1'b1;
        step();
        rst = 1'b0; rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            errors++; $display("FAIL in_reset actual=%0b/%0b required=0/0", rvalid, arready);
        end
        step();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || awready !== 1'b1) begin
            errors++; $display("FAIL after_reset actual=%0b/%0b/%0b required=0/1/1",
                               rvalid, arready, awready);
        end
    endtask

    task automatic test_collision();
        wd[0] = {64{8'h5E}}; ws[0] = '1;
        write_burst(64'h140, 0, 8'h90, -1, 0);
        awvalid = 1'b1; awaddr = 64'h140; awlen = 4'd0; awid = 8'h91;
        arvalid = 1'b1; araddr = 64'h140; arlen = 4'd0; arid = 8'h92;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        wvalid = 1'b1; wdata = {64{8'hE7}}; wstrb = '1; wlast = 1'b1; rready = 1'b1;
        #1;
        checks++;
        if (wready !== 1'b1 || rvalid !== 1'b1 || rdata !== {64{8'h5E}}) begin
            errors++; $display("FAIL collision_old actual=%0b/%0b/%0h required=1/1/%0h",
                               wready, rvalid, rdata, {64{8'h5E}});
        end
        step();
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b1 || bid !== 8'h91) begin
            errors++; $display("FAIL collision_after actual=%0b/%0b/%0h required=0/1/91",
                               rvalid, bvalid, bid);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        exp_q[0] = {64{8'hE7}};
        read_burst(64'h140, 0, 8'h93, 0);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_strobed_burst();
        test_backpressure();
        test_wrap();
        test_wlast();
        test_reset_mid_burst();
        test_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
